// File: rtl/psp_trace_pkg.sv
// Shared types for the RVFI retirement trace transmitter.
// Record layout, frame constants and serializer states.
package psp_trace_pkg;

  localparam logic [7:0] TRACE_SYNC_BYTE   = 8'hA5;
  localparam int         TRACE_FRAME_BYTES = 17;

  typedef struct packed {
    logic [31:0] rd_wdata;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [31:0] order32;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } trace_state_t;

endpackage

// File: rtl/rvfi_trace_tx_fifo.sv
// Synchronous record FIFO for the trace transmitter.
// Extra pointer bit separates full from empty.
module trace_fifo
  import psp_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  trace_rec_t wdata_i,
  input  logic       pop_i,
  output trace_rec_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t     mem_q [DEPTH];
  logic  [AW:0]   wr_q;
  logic  [AW:0]   rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0])
                && (wr_q[AW] != rd_q[AW]);

endmodule

// File: rtl/rvfi_trace_tx.sv
// RVFI retirement trace: order numbering, record FIFO and
// framed UART 8N1 serializer (sync byte + 16 record bytes).
module rvfi_trace_tx
  import psp_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [31:0] rvfi_insn,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] dropped_count,
  output logic [63:0] order
);

  trace_state_t state_q, state_d;

  logic [15:0]  cnt_q;
  logic [2:0]   bit_q;
  logic [4:0]   idx_q;
  logic [7:0]   byte_q;
  logic [127:0] rec_q;
  logic [63:0]  order_q;
  logic         ovf_q;
  logic [15:0]  drop_q;

  trace_rec_t rec_in, head;
  logic       full, empty;
  logic       pop, push, drop;
  logic       bit_end, last_byte;

  assign rec_in.rd_wdata = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
  assign rec_in.insn     = rvfi_insn;
  assign rec_in.pc       = rvfi_pc_rdata;
  assign rec_in.order32  = order_q[31:0];

  assign pop  = (state_q == IDLE) && !empty;
  // a pop on this edge frees a slot, so a full FIFO still accepts
  assign push = rvfi_valid && (!full || pop);
  assign drop = rvfi_valid && full && !pop;

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (rec_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bit_end   = (cnt_q == 16'(CLKS_PER_BIT - 1));
  assign last_byte = (idx_q >= 5'(TRACE_FRAME_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!empty) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_q == 3'd7) state_d = STOP;
      STOP:  if (bit_end) state_d = last_byte ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = byte_q[bit_q];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      idx_q  <= '0;
      byte_q <= TRACE_SYNC_BYTE;
      rec_q  <= '0;
    end else begin
      if (state_q == IDLE || bit_end) cnt_q <= '0;
      else                            cnt_q <= cnt_q + 16'd1;
      if (pop) begin
        rec_q  <= head;
        byte_q <= TRACE_SYNC_BYTE;
        idx_q  <= '0;
        bit_q  <= '0;
      end
      if (state_q == DATA && bit_end) bit_q <= bit_q + 3'd1;
      // next byte comes from the low end of the record
      if (state_q == STOP && bit_end && !last_byte) begin
        idx_q  <= idx_q + 5'd1;
        byte_q <= rec_q[7:0];
        rec_q  <= rec_q >> 8;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      order_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else if (rvfi_valid) begin
      order_q <= order_q + 64'd1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign busy          = (state_q != IDLE) || !empty;
  assign overflow      = ovf_q;
  assign dropped_count = drop_q;
  assign order         = order_q;

endmodule

// File: tb/tb_rvfi_trace_tx.sv
// Directed bench for rvfi_trace_tx: decodes UART frames
// from tx and checks fields, drops, reset and saturation.
module tb_rvfi_trace_tx;

  localparam int CPB       = 4;
  localparam int BYTE_CYC  = 10 * CPB;
  localparam int FRAME_CYC = 17 * BYTE_CYC;
  localparam int SAT_CYC   = 65800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rvfi_valid = 1'b0;
  logic [31:0] rvfi_insn = '0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [15:0] dropped_count;
  logic [63:0] order;

  int n_vec = 0;
  int n_bad = 0;

  logic [FRAME_CYC-1:0] samp;
  logic [7:0]           fb [17];

  always #5 clk = ~clk;

  rvfi_trace_tx #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rvfi_valid    (rvfi_valid),
    .rvfi_insn     (rvfi_insn),
    .rvfi_pc_rdata (rvfi_pc_rdata),
    .rvfi_rd_addr  (rvfi_rd_addr),
    .rvfi_rd_wdata (rvfi_rd_wdata),
    .tx            (tx),
    .busy          (busy),
    .overflow      (overflow),
    .dropped_count (dropped_count),
    .order         (order)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic retire(input logic [31:0] p,
                        input logic [31:0] i,
                        input logic [4:0]  r,
                        input logic [31:0] w);
    rvfi_pc_rdata = p;
    rvfi_insn     = i;
    rvfi_rd_addr  = r;
    rvfi_rd_wdata = w;
    rvfi_valid    = 1'b1;
    @(negedge clk);
    rvfi_valid    = 1'b0;
  endtask

  task automatic rx_frame();
    int t = 0;
    int ferr = 0;
    while (tx !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_vec++;
      n_bad++;
      $display("FAIL rx_timeout: got no start bit want start bit");
      return;
    end
    samp[0] = tx;
    for (int j = 1; j < FRAME_CYC; j++) begin
      @(negedge clk);
      samp[j] = tx;
    end
    for (int k = 0; k < 17; k++) begin
      if (samp[k*BYTE_CYC + 2] !== 1'b0)  ferr++;
      if (samp[k*BYTE_CYC + 38] !== 1'b1) ferr++;
      for (int b = 0; b < 8; b++)
        fb[k][b] = samp[k*BYTE_CYC + CPB*(1+b) + 2];
    end
    chk("framing", 64'(ferr), 64'd0);
  endtask

  function automatic logic [31:0] fld(input int k);
    return {fb[k+3], fb[k+2], fb[k+1], fb[k]};
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx",    tx, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_drop",  dropped_count, 0);
    chk("rst_order", order, 0);
    reset = 1'b0;
    @(negedge clk);

    // single retirement
    retire(32'h6000_0000, 32'h0010_0093, 5'd1, 32'd1);
    chk("t1_tx_hold", tx, 1);
    chk("t1_busy",    busy, 1);
    @(negedge clk);
    chk("t1_tx_fall", tx, 0);
    rx_frame();
    chk("t1_sync",  fb[0], 8'hA5);
    chk("t1_order", fld(1), 32'h0);
    chk("t1_pc",    fld(5), 32'h6000_0000);
    chk("t1_insn",  fld(9), 32'h0010_0093);
    chk("t1_wdata", fld(13), 32'h1);
    @(negedge clk);
    chk("t1_busy_end", busy, 0);
    chk("t1_order_o",  order, 1);

    // x0 destination masks write data
    retire(32'h6000_0004, 32'h0000_0013, 5'd0, 32'hDEAD_BEEF);
    rx_frame();
    chk("t2_order", fld(1), 32'h1);
    chk("t2_wdata", fld(13), 32'h0);
    @(negedge clk);

    // burst of 6 with one drop, then push on a pop-from-full edge
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fork
      rx_frame();
      begin
        for (int i = 0; i < 6; i++)
          retire(32'h1000 + 32'(4*i), 32'h13, 5'(i+1), 32'(i));
        chk("t3_ovf",   overflow, 1);
        chk("t3_drop",  dropped_count, 1);
        chk("t3_order", order, 6);
      end
    join
    chk("t3_f0_order", fld(1), 32'd0);
    chk("t3_f0_pc",    fld(5), 32'h1000);
    @(negedge clk);
    retire(32'h2000, 32'h13, 5'd2, 32'h55);
    chk("t4_drop",  dropped_count, 1);
    chk("t4_order", order, 7);
    for (int f = 1; f < 6; f++) begin
      rx_frame();
      chk($sformatf("t3_f%0d_order", f), fld(1),
          (f == 5) ? 32'd6 : 32'(f));
      chk($sformatf("t3_f%0d_pc", f), fld(5),
          (f == 5) ? 32'h2000 : 32'h1000 + 32'(4*f));
    end
    @(negedge clk);
    chk("t3_busy_end", busy, 0);

    // reset during byte 7 with records queued
    retire(32'h4000, 32'h13, 5'd1, 32'h1);
    retire(32'h4004, 32'h13, 5'd1, 32'h2);
    retire(32'h4008, 32'h13, 5'd1, 32'h3);
    repeat (7*BYTE_CYC + 10 - 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_tx",    tx, 1);
    chk("t5_busy",  busy, 0);
    chk("t5_order", order, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_flush", busy, 0);
    retire(32'h3000, 32'h0020_0113, 5'd2, 32'h77);
    rx_frame();
    chk("t5_sync",  fb[0], 8'hA5);
    chk("t5_order_f", fld(1), 32'd0);
    chk("t5_pc",    fld(5), 32'h3000);
    chk("t5_wdata", fld(13), 32'h77);
    @(negedge clk);

    // drop counter saturation
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rvfi_pc_rdata = 32'h5000;
    rvfi_rd_addr  = 5'd3;
    rvfi_valid    = 1'b1;
    repeat (SAT_CYC) @(negedge clk);
    chk("t6_drop",  dropped_count, 16'hFFFF);
    chk("t6_ovf",   overflow, 1);
    chk("t6_order", order, 64'(SAT_CYC));
    @(negedge clk);
    chk("t6_drop_hold", dropped_count, 16'hFFFF);
    rvfi_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rvfi_trace_tx.md
Name: rvfi_trace_tx

Overview:
- Sits inside psp on coreclk and consumes the core's RVFI retirement stream, i.e. the producer side of the instruction trace that the host-side decoder receives.
- Numbers each retirement with a 64-bit order counter.
- Buffers compact records in a small FIFO.
- Serializes each record as a framed UART 8N1 byte stream on a single pin, so a board-level host can check retirement without a simulator-side RVFI monitor.

Parameters:
- CLKS_PER_BIT, 868, coreclk cycles per UART bit (legal range 2..65535).
- DEPTH, 4, FIFO record entries (power of 2, at least 2).

Ports:
- clk  in  1  core clock (coreclk)
- reset  in  1  synchronous, active-high reset
- rvfi_valid  in  1  one instruction retires this cycle
- rvfi_insn  in  32  retired instruction word
- rvfi_pc_rdata  in  32  PC of retired instruction
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- tx  out  1  UART serial out, idles high
- busy  out  1  frame in progress or FIFO non-empty
- overflow  out  1  sticky: at least one record dropped
- dropped_count  out  16  saturating count of dropped records
- order  out  64  number of retirements since reset

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; all state changes only on the rising edge of clk.
- Reset values: tx=1, busy=0, overflow=0, dropped_count=0, order=0. FIFO is empty, FSM is in IDLE.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and tx=1 from the reset edge onward.
- order: increments by 1 on every edge where rvfi_valid=1, including dropped records, so gaps in transmitted order values expose drops. Wraps modulo 2^64.
- Record captured on a valid edge, 128 bits: {rd_wdata', insn, pc_rdata, order[31:0]}.
  - The order field is the value before the increment, so the first record has order 0.
  - rd_wdata' = 0 when rd_addr == 0, otherwise rvfi_rd_wdata.
- FIFO push when rvfi_valid=1 and the FIFO is not full.
  - When full, the record is dropped: overflow<=1 and dropped_count<=dropped_count+1, saturating at 0xFFFF.
  - Push on the same edge as a pop from full is accepted (no drop).
- FSM states and transitions:
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into a 128-bit shift record, byte index <= 0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index < 16: increment it and go to START. Otherwise go to IDLE.
  - There is no idle gap between bytes of a frame.
  - Back-to-back frames: at least one IDLE cycle between the last stop bit and the next start bit.
- Frame format: 17 bytes total.
  - Byte 0 is the sync byte 0xA5.
  - Bytes 1..16 are the record, little-endian: order[31:0], pc, insn, rd_wdata'.
- Latency: the record sampled at edge N enters the FIFO at edge N. With the FSM in IDLE, the pop happens at edge N+1 and tx falls at edge N+1.
- busy = (state != IDLE) | FIFO non-empty; registered-equivalent, no combinational path from rvfi_valid.
- Counter widths: bit counter is 16 bits; byte index is 5 bits.

Decomposition:
- Package psp_trace_pkg holds:
  - TRACE_SYNC_BYTE = 8'hA5
  - TRACE_FRAME_BYTES = 17
  - typedef struct packed trace_rec_t {rd_wdata, insn, pc, order32}
  - typedef enum trace_state_t {IDLE, START, DATA, STOP}
- One sub-module, trace_fifo: synchronous FIFO of trace_rec_t, DEPTH entries, with full/empty flags and same-cycle push+pop support.
- The FSM and bit timing stay in rvfi_trace_tx.

Test Plan (CLKS_PER_BIT=4, DEPTH=4 unless stated):
- Single retirement: pc=0x60000000, insn=0x00100093, rd=1, wdata=1 -> tx falls 1 cycle after the sample edge; decoded bytes are A5 00 00 00 00 | 00 00 00 60 | 93 00 10 00 | 01 00 00 00; busy falls after 17*40 cycles; order=1.
- rd_addr=0 with wdata=0xDEADBEEF -> last 4 payload bytes are 00 00 00 00.
- 6 consecutive valid cycles -> transmitted orders 0,1,2,3,4; record 5 dropped; overflow=1; dropped_count=1; order=6.
- Push on the same edge as a pop while the FIFO is full -> no drop; dropped_count is unchanged.
- Assert reset during byte 7 of a frame -> tx=1 at the next edge; busy=0; order=0; a later retirement produces a clean frame with order 0.
- Force dropped_count to 0xFFFF, then keep the FIFO full and retire one more -> value stays 0xFFFF.
